// File: rtl/stall_ctrl.sv
// stall_ctrl: central pipeline stall/flush sequencer for the 5-stage MIPS32 core.
// Merges ID and EX stall requests into one stall vector and sequences EX multi-cycle
// operations (EX reports only "start, N cycles"; the countdown lives here).
// Optional performance counters are compiled in with STALL_CTRL_PERF_EN.
module stall_ctrl #(
    parameter int unsigned MC_CNT_W = 6,
    parameter int unsigned STALL_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                stallreq_id_i,
    input  logic                stallreq_ex_i,
    input  logic                mc_start_i,
    input  logic [MC_CNT_W-1:0] mc_cycles_i,
    output logic [STALL_W-1:0]  stall_o,
    output logic                mc_busy_o,
    output logic                mc_done_o,
    output logic [MC_CNT_W-1:0] mc_cnt_o
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [31:0]         stall_cycles_o,
    output logic [15:0]         flush_count_o
`endif
);

    // Bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
    localparam logic [STALL_W-1:0] StallEx   = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] StallId   = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] StallNone = '0;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic                seq_stall;
    logic                seq_done;

    // Sequencer next state; cnt holds the EX cycles still to go, including the current one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_stall = 1'b0;
        seq_done  = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // N <= 1 is a single-cycle op: nothing to sequence.
                    if (mc_start_i && (mc_cycles_i >= MC_CNT_W'(2))) begin
                        seq_stall = 1'b1;
                        state_d   = StBusy;
                        cnt_d     = mc_cycles_i - MC_CNT_W'(1);
                    end
                end
                StBusy: begin
                    // mc_start_i stays high while EX is held, so it is ignored here.
                    if (cnt_q > MC_CNT_W'(1)) begin
                        seq_stall = 1'b1;
                        cnt_d     = cnt_q - MC_CNT_W'(1);
                    end else begin
                        seq_done = (cnt_q == MC_CNT_W'(1));
                        state_d  = StIdle;
                        cnt_d    = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall vector priority: reset, flush, EX side, ID side.
    always_comb begin
        stall_o = StallNone;
        if (!rst || flush_i) begin
            stall_o = StallNone;
        end else if (stallreq_ex_i || seq_stall) begin
            stall_o = StallEx;
        end else if (stallreq_id_i) begin
            stall_o = StallId;
        end
    end

    // Status outputs; done is gated so reset forces it low immediately.
    always_comb begin
        mc_busy_o = (state_q == StBusy);
        mc_done_o = seq_done & rst;
        mc_cnt_o  = cnt_q;
    end

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    // Saturating counters of PC-stall cycles and flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_o[0] && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush_i && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Testbench for stall_ctrl: a cycle table from reset, hand-written multi-cycle sequences,
// and randomized stimulus checked against an operation-level reference model.
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush_i = 1'b0;
    logic       stallreq_id_i = 1'b0;
    logic       stallreq_ex_i = 1'b0;
    logic       mc_start_i = 1'b0;
    logic [5:0] mc_cycles_i = '0;
    logic [5:0] stall_o;
    logic       mc_busy_o;
    logic       mc_done_o;
    logic [5:0] mc_cnt_o;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
`endif

    stall_ctrl #(.MC_CNT_W(6), .STALL_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .stallreq_id_i (stallreq_id_i),
        .stallreq_ex_i (stallreq_ex_i),
        .mc_start_i    (mc_start_i),
        .mc_cycles_i   (mc_cycles_i),
        .stall_o       (stall_o),
        .mc_busy_o     (mc_busy_o),
        .mc_done_o     (mc_done_o),
        .mc_cnt_o      (mc_cnt_o)
`ifdef STALL_CTRL_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o (flush_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model at operation level: one op of length m_n, m_k cycles already elapsed.
    bit m_in_op = 1'b0;
    int m_n     = 0;
    int m_k     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int exp_stall();
        bit seq;
        if (flush_i) return 0;
        if (m_in_op) seq = (m_k < m_n - 1);
        else         seq = mc_start_i && (int'(mc_cycles_i) >= 2);
        if (stallreq_ex_i || seq) return 6'b001111;
        if (stallreq_id_i) return 6'b000111;
        return 0;
    endfunction

    function automatic int exp_done();
        return (!flush_i && m_in_op && (m_k == m_n - 1)) ? 1 : 0;
    endfunction

    function automatic int exp_cnt();
        return m_in_op ? (m_n - m_k) : 0;
    endfunction

    task automatic model_clock();
        if (flush_i) begin
            m_in_op = 1'b0;
        end else if (m_in_op) begin
            m_k++;
            if (m_k == m_n) m_in_op = 1'b0;
        end else if (mc_start_i && int'(mc_cycles_i) >= 2) begin
            m_in_op = 1'b1;
            m_n     = int'(mc_cycles_i);
            m_k     = 1;
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are sampled at the falling edge.
    task automatic apply(input bit f, input bit id, input bit ex, input bit st, input int n);
        flush_i       = f;
        stallreq_id_i = id;
        stallreq_ex_i = ex;
        mc_start_i    = st;
        mc_cycles_i   = 6'(n);
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".stall"}, int'(stall_o), exp_stall());
        chk({tag, ".busy"}, int'(mc_busy_o), int'(m_in_op));
        chk({tag, ".done"}, int'(mc_done_o), exp_done());
        chk({tag, ".cnt"}, int'(mc_cnt_o), exp_cnt());
    endtask

    task automatic step(input string tag, input bit f, input bit id, input bit ex, input bit st,
                        input int n);
        apply(f, id, ex, st, n);
        check_model(tag);
        finish_cycle();
    endtask

    typedef struct {
        bit       f, id, ex, st;
        int       n;
        int       stall;
        int       busy, done, cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit f, bit id, bit ex, bit st, int n, int stall, int busy,
                                int done, int cnt);
        vec_t v;
        v.f = f; v.id = id; v.ex = ex; v.st = st; v.n = n;
        v.stall = stall; v.busy = busy; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    int stall_seen;
    int done_seen;

    initial begin
        // Consecutive cycles from IDLE: f id ex st n | stall busy done cnt
        tbl[0]  = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 6'b000111, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 6'b001111, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 6'b001111, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1, 1, 9, 6'b000000, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1, 6'b000000, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 0, 6'b000000, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 3, 6'b001111, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 3, 6'b001111, 1, 0, 2);
        tbl[9]  = mk(0, 1, 0, 1, 3, 6'b000111, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 2, 6'b001111, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 1, 2, 6'b001111, 1, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 1, 4, 6'b001111, 0, 0, 0);
        tbl[15] = mk(1, 1, 0, 1, 4, 6'b000000, 1, 0, 3);
        tbl[16] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

        // Reset held with requests active: every output must stay 0.
        rst = 1'b0;
        mc_start_i = 1'b1;
        mc_cycles_i = 6'd5;
        stallreq_id_i = 1'b1;
        @(negedge clk);
        chk("rst.stall", int'(stall_o), 0);
        chk("rst.busy", int'(mc_busy_o), 0);
        chk("rst.cnt", int'(mc_cnt_o), 0);
        @(negedge clk);
        chk("rst.stall2", int'(stall_o), 0);
        chk("rst.done", int'(mc_done_o), 0);
        @(posedge clk);
        #1;
        mc_start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst.release_id", int'(stall_o), 6'b000111);
        finish_cycle();

        // Table-driven cycle sequence.
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].f, tbl[i].id, tbl[i].ex, tbl[i].st, tbl[i].n);
            chk($sformatf("tbl%0d.stall", i), int'(stall_o), tbl[i].stall);
            chk($sformatf("tbl%0d.busy", i), int'(mc_busy_o), tbl[i].busy);
            chk($sformatf("tbl%0d.done", i), int'(mc_done_o), tbl[i].done);
            chk($sformatf("tbl%0d.cnt", i), int'(mc_cnt_o), tbl[i].cnt);
            finish_cycle();
        end

        // DIV, N=36: 35 stall cycles and exactly one done pulse with cnt 1.
        stall_seen = 0;
        done_seen  = 0;
        for (int c = 0; c < 38; c++) begin
            apply(0, 0, 0, (c <= 35), 36);
            check_model($sformatf("div.c%0d", c));
            if (stall_o == 6'b001111) stall_seen++;
            if (mc_done_o) begin
                done_seen++;
                chk("div.done_cycle", c, 35);
                chk("div.done_cnt", int'(mc_cnt_o), 1);
            end
            finish_cycle();
        end
        chk("div.stall_cycles", stall_seen, 35);
        chk("div.done_pulses", done_seen, 1);

        // Single-cycle starts never engage the sequencer.
        for (int c = 0; c < 4; c++) begin
            apply(0, 0, 0, 1, c % 2);
            chk("n01.stall", int'(stall_o), 0);
            chk("n01.busy", int'(mc_busy_o), 0);
            chk("n01.done", int'(mc_done_o), 0);
            finish_cycle();
        end

        // Flush at cycle 5 of an N=10 op; no done pulse afterwards.
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            apply((c == 5), 0, 0, (c <= 5), 10);
            check_model($sformatf("flush.c%0d", c));
            if (c == 5) chk("flush.c5_stall", int'(stall_o), 0);
            if (c == 6) chk("flush.c6_cnt", int'(mc_cnt_o), 0);
            if (mc_done_o) done_seen++;
            finish_cycle();
        end
        chk("flush.no_done", done_seen, 0);

        // ID request held through a BUSY op of N=4.
        for (int c = 0; c < 6; c++) begin
            apply(0, 1, 0, (c <= 3), 4);
            check_model($sformatf("idbusy.c%0d", c));
            if (c == 3) chk("idbusy.done_stall", int'(stall_o), 6'b000111);
            finish_cycle();
        end

        // Async reset at cycle 3 of an N=8 op: outputs clear before the next edge.
        for (int c = 0; c < 3; c++) step("arst.pre", 0, 0, 0, 1, 8);
        apply(0, 1, 0, 1, 8);
        chk("arst.pre_cnt", int'(mc_cnt_o), 5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.stall", int'(stall_o), 0);
        chk("arst.busy", int'(mc_busy_o), 0);
        chk("arst.done", int'(mc_done_o), 0);
        chk("arst.cnt", int'(mc_cnt_o), 0);
        @(posedge clk);
        #1;
        m_in_op = 1'b0;
        rst = 1'b1;
        step("arst.n2a", 0, 0, 0, 1, 2);
        apply(0, 0, 0, 1, 2);
        check_model("arst.n2b");
        chk("arst.n2_done", int'(mc_done_o), 1);
        finish_cycle();
        step("arst.n2c", 0, 0, 0, 0, 0);

        // Randomized stimulus against the reference model, including N at its maximum.
        for (int c = 0; c < 600; c++) begin
            bit f, id, ex, st;
            int n;
            f  = ($urandom_range(0, 15) == 0);
            id = $urandom_range(0, 2) == 0;
            ex = $urandom_range(0, 5) == 0;
            st = $urandom_range(0, 1) == 1;
            n  = ($urandom_range(0, 19) == 0) ? 63 : $urandom_range(0, 12);
            step("rand", f, id, ex, st, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
